// File: rtl/song_sequencer.sv
// Song sequencer: play/pause/next/prev control with per-song restart pulse and gated sample register.
// Define SONG_SEQUENCER_AUTO_ADVANCE_EN to move to the next song and keep playing when a song ends.
module song_sequencer #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2,
    parameter int SAMPLE_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                play_button,
    input  logic                next_button,
    input  logic                prev_button,
    input  logic                song_done,
    input  logic                new_frame,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SONG_W-1:0]   current_song,
    output logic                play,
    output logic                song_reset,
    output logic [SAMPLE_W-1:0] sample_out
);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        PLAY   = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

    state_t            state;
    state_t            state_next;
    logic [SONG_W-1:0] song_next;
    logic [SONG_W-1:0] song_inc;
    logic [SONG_W-1:0] song_dec;

    logic play_prev;
    logic next_prev;
    logic prev_prev;
    logic edge_armed;
    logic play_edge;
    logic next_edge;
    logic prev_edge;

    // The armed flag keeps a button that is already held at reset release from counting as a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            play_prev  <= 1'b0;
            next_prev  <= 1'b0;
            prev_prev  <= 1'b0;
            edge_armed <= 1'b0;
        end else begin
            play_prev  <= play_button;
            next_prev  <= next_button;
            prev_prev  <= prev_button;
            edge_armed <= 1'b1;
        end
    end

    assign play_edge = edge_armed & play_button & ~play_prev;
    assign next_edge = edge_armed & next_button & ~next_prev;
    assign prev_edge = edge_armed & prev_button & ~prev_prev;

    assign song_inc = (current_song == LAST_SONG)  ? '0        : current_song + SONG_W'(1);
    assign song_dec = (current_song == '0)         ? LAST_SONG : current_song - SONG_W'(1);

`ifdef SONG_SEQUENCER_AUTO_ADVANCE_EN
    logic resume_play;
    logic resume_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resume_play <= 1'b0;
        end else begin
            resume_play <= resume_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PAUSED;
            current_song <= '0;
        end else begin
            state        <= state_next;
            current_song <= song_next;
        end
    end

    // Priority is next > prev > song_done > play; anything lower in the same cycle is dropped.
    always_comb begin
        state_next = state;
        song_next  = current_song;
`ifdef SONG_SEQUENCER_AUTO_ADVANCE_EN
        resume_next = resume_play;
`endif
        if (next_edge) begin
            song_next  = song_inc;
            state_next = SWITCH;
`ifdef SONG_SEQUENCER_AUTO_ADVANCE_EN
            resume_next = 1'b0;
`endif
        end else if (prev_edge) begin
            song_next  = song_dec;
            state_next = SWITCH;
`ifdef SONG_SEQUENCER_AUTO_ADVANCE_EN
            resume_next = 1'b0;
`endif
        end else begin
            case (state)
                PAUSED: begin
                    if (play_edge) begin
                        state_next = PLAY;
                    end
                end
                PLAY: begin
                    if (song_done) begin
`ifdef SONG_SEQUENCER_AUTO_ADVANCE_EN
                        song_next   = song_inc;
                        state_next  = SWITCH;
                        resume_next = 1'b1;
`else
                        state_next  = PAUSED;
`endif
                    end else if (play_edge) begin
                        state_next = PAUSED;
                    end
                end
                SWITCH: begin
`ifdef SONG_SEQUENCER_AUTO_ADVANCE_EN
                    state_next  = resume_play ? PLAY : PAUSED;
                    resume_next = 1'b0;
`else
                    state_next  = PAUSED;
`endif
                end
                default: begin
                    state_next = PAUSED;
                end
            endcase
        end
    end

    assign play       = (state == PLAY);
    assign song_reset = (state == SWITCH);

    // Paused frames send silence rather than whatever the synthesis path is producing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_out <= '0;
        end else if (new_frame) begin
            sample_out <= play ? sample_in : '0;
        end
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter NUM_SONGS, default 4, number of selectable songs (2..2**SONG_W).
REQ-002 SHALL have parameter SONG_W, default 2, width of song index.
REQ-003 SHALL have parameter SAMPLE_W, default 16, audio sample width (signed two's complement).
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port play_button  input  1  play/pause toggle request, level.
REQ-007 SHALL have port next_button  input  1  next-song request, level.
REQ-008 SHALL have port prev_button  input  1  previous-song request, level.
REQ-009 SHALL have port song_done  input  1  one-cycle pulse from note engine at end of current song.
REQ-010 SHALL have port new_frame  input  1  codec sample-accept strobe, one cycle per frame.
REQ-011 SHALL have port sample_in  input  SAMPLE_W  sample from synthesis path.
REQ-012 SHALL have port current_song  output  SONG_W  selected song index.
REQ-013 SHALL have port play  output  1  high while in PLAY state.
REQ-014 SHALL have port song_reset  output  1  one-cycle pulse restarting note engine at song start.
REQ-015 SHALL have port sample_out  output  SAMPLE_W  registered sample to codec.

Function
REQ-016 SHALL rising-edge-detect each button (registered previous level); a held button SHALL act exactly once.
REQ-017 SHALL implement FSM states PAUSED, PLAY, SWITCH; play = (state == PLAY).
REQ-018 SHALL, on play edge, go PAUSED->PLAY or PLAY->PAUSED the next cycle; in SWITCH it SHALL be ignored.
REQ-019 SHALL, on next edge, set current_song to (current_song+1) wrapping NUM_SONGS-1->0, enter SWITCH.
REQ-020 SHALL, on prev edge, set current_song to (current_song-1) wrapping 0->NUM_SONGS-1, enter SWITCH.
REQ-021 SHALL assert song_reset for exactly the one cycle in SWITCH, then go PAUSED, unless REQ-031 applies.
REQ-022 SHALL apply same-cycle priority next > prev > song_done > play; lower-priority events that cycle are dropped.
REQ-023 SHALL ignore song_done outside PLAY.
REQ-024 SHALL, on new_frame, load sample_out with sample_in if play=1, else with 0; hold otherwise; latency 1 cycle.
REQ-025 SHALL, on song change, index only through 0..NUM_SONGS-1 for non-power-of-2 NUM_SONGS.

Reset
REQ-026 SHALL, while reset_n=0, force state PAUSED, current_song=0, play=0, song_reset=0, sample_out=0, edge registers=0.
REQ-027 SHALL, when reset_n asserts mid-SWITCH or mid-PLAY, abort immediately with no song_reset pulse.
REQ-028 SHALL not treat a button already high at reset release as an edge.

Configuration
REQ-029 SHALL use macro SONG_SEQUENCER_AUTO_ADVANCE_EN.
REQ-030 SHALL, without the macro, on song_done in PLAY, go PAUSED with current_song unchanged, no song_reset.
REQ-031 SHALL, with the macro, on song_done in PLAY, advance as next (REQ-019) through SWITCH, then return to PLAY, not PAUSED.

Verification
REQ-032 SHALL cover: reset release, play pulse -> play=1 after 1 cycle; new_frame with sample_in=16'h1234 -> sample_out=16'h1234 next cycle.
REQ-033 SHALL cover: play pulse while playing -> play=0; new_frame with sample_in=16'h7FFF -> sample_out=0.
REQ-034 SHALL cover: current_song=3, NUM_SONGS=4, next -> current_song=0, song_reset 1 cycle, play=0; prev from 0 -> 3.
REQ-035 SHALL cover: next and play same cycle -> only song change; play_button held 10 cycles -> one toggle.
REQ-036 SHALL cover: song_done in PLAY on song 1 -> with macro song 2 playing after SWITCH; without macro song 1, play=0.
REQ-037 SHALL cover: reset_n low during SWITCH -> current_song=0, song_reset=0 same cycle, NUM_SONGS=3 wrap 2->0.
